reg_file_clr: RTL and testbench



---
 rtl/reg_file_clr.sv | 112 +++++++++++
 tb/tb_reg_file_clr.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_clr.sv
// Parametrised register file: two combinational read ports, one clocked write
// port, and a request-driven engine that zeroes every entry one per cycle.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_clr #(
  parameter int DW       = 4,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3*AW-1:0] instruction,
  input  logic            reg_write,
  input  logic [DW-1:0]   data_write,
  input  logic            clear_req,
  output logic [DW-1:0]   data_read_1,
  output logic [DW-1:0]   data_read_2,
  output logic            busy,
  output logic            clear_done
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] regs [DEPTH];

  logic [AW-1:0] rd1_addr;
  logic [AW-1:0] rd2_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_is_zero_reg;
  logic          write_en;

  assign rd1_addr       = instruction[3*AW-1:2*AW];
  assign rd2_addr       = instruction[2*AW-1:AW];
  assign wr_addr        = instruction[AW-1:0];
  assign wr_is_zero_reg = (ZERO_REG != 0) && (wr_addr == '0);
  // Writes are dropped outside IDLE and never queued.
  assign write_en       = reg_write && (state == IDLE) && !wr_is_zero_reg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == PTR_LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          clear_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array is deliberately reset; every entry must read 0 after
  // rst_n, which rules out a plain RAM macro without a reset port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[ptr] <= '0;
    end else if (write_en) begin
      regs[wr_addr] <= data_write;
    end
  end

  // NOTE: each output gets an unconditional default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    data_read_1 = regs[rd1_addr];
    data_read_2 = regs[rd2_addr];
`ifdef REGFILE_BYPASS_EN
    if (write_en && (wr_addr == rd1_addr)) data_read_1 = data_write;
    if (write_en && (wr_addr == rd2_addr)) data_read_2 = data_write;
`endif
    if ((ZERO_REG != 0) && (rd1_addr == '0)) data_read_1 = '0;
    if ((ZERO_REG != 0) && (rd2_addr == '0)) data_read_2 = '0;
  end

endmodule

// File: tb/tb_reg_file_clr.sv
// Self-checking bench for reg_file_clr: directed scenarios pinned by literals,
// then random traffic checked every cycle against a behavioural model.
module tb_reg_file_clr;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3*AW-1:0] instruction = '0;
  logic            reg_write = 1'b0;
  logic [DW-1:0]   data_write = '0;
  logic            clear_req = 1'b0;

  logic [DW-1:0] z_rd1, z_rd2, n_rd1, n_rd2;
  logic          z_busy, z_done, n_busy, n_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_clr #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .reg_write(reg_write),
    .data_write(data_write), .clear_req(clear_req), .data_read_1(z_rd1),
    .data_read_2(z_rd2), .busy(z_busy), .clear_done(z_done)
  );

  reg_file_clr #(.DW(DW), .AW(AW), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .reg_write(reg_write),
    .data_write(data_write), .clear_req(clear_req), .data_read_1(n_rd1),
    .data_read_2(n_rd2), .busy(n_busy), .clear_done(n_done)
  );

  // Model: phase 0 = idle, 1..DEPTH = clearing entry phase-1, DEPTH+1 = done.
  logic [DW-1:0] mem_z [DEPTH] = '{default: '0};
  logic [DW-1:0] mem_n [DEPTH] = '{default: '0};
  int            phase = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_z[i] = '0;
        mem_n[i] = '0;
      end
    end else if (phase == 0) begin
      if (reg_write) begin
        if (instruction[AW-1:0] != 0) mem_z[instruction[AW-1:0]] = data_write;
        mem_n[instruction[AW-1:0]] = data_write;
      end
      if (clear_req) phase = 1;
    end else if (phase <= DEPTH) begin
      mem_z[phase-1] = '0;
      mem_n[phase-1] = '0;
      phase++;
    end else begin
      phase = 0;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input bit zr, input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = instruction[AW-1:0];
    if (zr && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write && phase == 0 && w == a && !(zr && w == 0)) return data_write;
`endif
    return zr ? mem_z[a] : mem_n[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [AW-1:0] a1, a2;
    logic          exp_busy, exp_done;
    a1 = instruction[3*AW-1:2*AW];
    a2 = instruction[2*AW-1:AW];
    exp_busy = (phase >= 1) && (phase <= DEPTH);
    exp_done = (phase == DEPTH + 1);
    check("z_rd1", z_rd1, exp_rd(1'b1, a1));
    check("z_rd2", z_rd2, exp_rd(1'b1, a2));
    check("n_rd1", n_rd1, exp_rd(1'b0, a1));
    check("n_rd2", n_rd2, exp_rd(1'b0, a2));
    check("z_busy", z_busy, exp_busy);
    check("z_done", z_done, exp_done);
    check("n_busy", n_busy, exp_busy);
    check("n_done", n_done, exp_done);
  end

  initial begin
    int busy_cnt, done_cnt, done_at;
    logic [DW-1:0] exp_bp;

    // Reset held: reads are zero.
    instruction = {4'd5, 4'd3, 4'd0};
    repeat (3) @(negedge clk);
    #1;
    check("reset_rd1", z_rd1, 4'h0);
    check("reset_rd2_nz", n_rd2, 4'h0);
    check("reset_busy", z_busy, 1'b0);
    step();
    rst_n = 1'b1;

    // Write 0xA to r5, read back.
    instruction = 12'h005; data_write = 4'hA; reg_write = 1'b1;
    step();
    reg_write = 1'b0; instruction = 12'h550;
    #1;
    check("r5_z", z_rd1, 4'hA);
    check("r5_n", n_rd1, 4'hA);

    // Write 0xF to r0: hardwired zero vs plain register.
    instruction = 12'h000; data_write = 4'hF; reg_write = 1'b1;
    step();
    reg_write = 1'b0;
    #1;
    check("r0_zero_reg", z_rd1, 4'h0);
    check("r0_plain", n_rd1, 4'hF);

    // Same-cycle forwarding to both ports.
    instruction = 12'h999; data_write = 4'h3; reg_write = 1'b1;
`ifdef REGFILE_BYPASS_EN
    exp_bp = 4'h3;
`else
    exp_bp = 4'h0;
`endif
    #1;
    check("bypass_rd1", z_rd1, exp_bp);
    check("bypass_rd2", z_rd2, exp_bp);
    step();
    reg_write = 1'b0;
    #1;
    check("r9_after_edge", z_rd1, 4'h3);

    // Fill r1..r15 with their own index.
    for (int i = 1; i < DEPTH; i++) begin
      instruction = 12'(i); data_write = 4'(i); reg_write = 1'b1;
      step();
    end
    reg_write = 1'b0;

    // Full clear with a stray re-request and a dropped write.
    instruction = {4'd8, 4'd3, 4'd0};
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 24; c++) begin
      if (z_busy) busy_cnt++;
      if (z_done) begin done_cnt++; done_at = c; end
      if (c == 8) check("r8_mid_clear", z_rd1, 4'h8);
      clear_req = (c == 5);
      reg_write = (c == 10);
      data_write = 4'h7;
      instruction = (c == 10) ? {4'd8, 4'd3, 4'd3} : {4'd8, 4'd3, 4'd0};
      step();
    end
    check("busy_cycles", busy_cnt, 16);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_at, 17);
    check("r3_after_clear", z_rd2, 4'h0);
    check("r8_after_clear", z_rd1, 4'h0);

    // Reset in the middle of a clear.
    instruction = {4'd7, 4'd7, 4'd7}; data_write = 4'h5; reg_write = 1'b1;
    step();
    reg_write = 1'b0; instruction = {4'd7, 4'd7, 4'd0};
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (4) step();
    check("busy_at_cycle5", z_busy, 1'b1);
    check("r7_retained", z_rd1, 4'h5);
    rst_n = 1'b0;
    #1;
    check("rst_busy", z_busy, 1'b0);
    check("rst_done", z_done, 1'b0);
    check("rst_r7_z", z_rd1, 4'h0);
    check("rst_r7_n", n_rd1, 4'h0);
    repeat (2) step();
    rst_n = 1'b1;

    // Held clear_req restarts after DONE: two pulses within 36 cycles.
    clear_req = 1'b1;
    done_cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      step();
      if (z_done) done_cnt++;
      if (k == 36) clear_req = 1'b0;
    end
    check("held_req_pulses", done_cnt, 2);

    // Random traffic, checked every cycle by the compare process.
    for (int k = 0; k < 800; k++) begin
      instruction = 12'($urandom);
      reg_write   = 1'($urandom_range(0, 1));
      data_write  = 4'($urandom);
      clear_req   = ($urandom_range(0, 39) == 0);
      rst_n       = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1; reg_write = 1'b0; clear_req = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
